// File: rtl/parking_pkg.sv
// Shared types for the parking lot lane arbiter.
// Holds the arbiter state encoding and the slot geometry of the lot.
package parking_pkg;

    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXIT  = 2'd1,
        ST_ENTRY = 2'd2,
        ST_HOLD  = 2'd3
    } park_state_e;

    typedef logic [SLOT_W-1:0] slot_idx_t;

endpackage

// File: rtl/parking_rr_picker.sv
// Combinational round-robin picker.
// Returns the first requester at or after ptr, wrapping to index 0.
module parking_rr_picker #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win_oh,
    output logic [PW-1:0] win_idx,
    output logic          win_vld
);

    int              j;
    logic [PW-1:0]   jj;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        win_vld = 1'b0;
        j       = 0;
        jj      = '0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            jj = PW'(j);
            if (!win_vld && req[jj]) begin
                win_vld     = 1'b1;
                win_idx     = jj;
                win_oh[jj]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/parking_lane_arbiter.sv
// Sequences the shared ParkingFSM between N entry lanes and one exit lane.
// Define PARK_ARB_STATS_EN to add saturating entry/exit/denied counters.
module parking_lane_arbiter
    import parking_pkg::*;
#(
    parameter int NUM_LANES   = 3,
    parameter int DOOR_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_LANES-1:0] lane_req,
    input  logic                 exit_req,
    input  logic [SLOT_W-1:0]    exit_loc,
    input  logic                 full_light,
    output logic                 entry_sensor,
    output logic                 exit_sensor,
    output logic [SLOT_W-1:0]    exit_location,
    output logic                 exit_ack,
    output logic [NUM_LANES-1:0] lane_grant,
    output logic [NUM_LANES-1:0] lane_blocked
`ifdef PARK_ARB_STATS_EN
    ,
    output logic [7:0]           stat_entries,
    output logic [7:0]           stat_exits,
    output logic [7:0]           stat_denied
`endif
);

    localparam int PW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int CW = $clog2(DOOR_CYCLES + 1);
    localparam logic [PW-1:0] LAST = PW'(NUM_LANES - 1);

    park_state_e           state_q;
    logic [PW-1:0]         ptr_q;
    logic [CW-1:0]         cnt_q;

    logic [NUM_LANES-1:0]  pick_oh;
    logic [PW-1:0]         pick_idx;
    logic                  pick_vld;
    logic                  entry_ok;
    logic [NUM_LANES-1:0]  blk_next;

    parking_rr_picker #(
        .N  (NUM_LANES),
        .PW (PW)
    ) u_picker (
        .req     (lane_req),
        .ptr     (ptr_q),
        .win_oh  (pick_oh),
        .win_idx (pick_idx),
        .win_vld (pick_vld)
    );

    // Exit wins over entry, so entry_ok is made exclusive of exit_req.
    assign entry_ok = !exit_req && !full_light && pick_vld;
    assign blk_next = lane_req & {NUM_LANES{full_light}};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            cnt_q         <= '0;
            entry_sensor  <= 1'b0;
            exit_sensor   <= 1'b0;
            exit_location <= '0;
            exit_ack      <= 1'b0;
            lane_grant    <= '0;
            lane_blocked  <= '0;
        end else begin
            entry_sensor <= 1'b0;
            exit_sensor  <= 1'b0;
            exit_ack     <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    lane_blocked <= blk_next;
                    unique case (1'b1)
                        exit_req: begin
                            state_q       <= ST_EXIT;
                            exit_sensor   <= 1'b1;
                            exit_ack      <= 1'b1;
                            exit_location <= exit_loc;
                        end
                        entry_ok: begin
                            state_q      <= ST_ENTRY;
                            entry_sensor <= 1'b1;
                            lane_grant   <= pick_oh;
                            ptr_q        <= (pick_idx == LAST) ? '0
                                          : pick_idx + PW'(1);
                        end
                        default: ;
                    endcase
                end
                ST_EXIT: begin
                    state_q       <= ST_IDLE;
                    exit_location <= '0;
                end
                ST_ENTRY: begin
                    state_q <= ST_HOLD;
                    cnt_q   <= CW'(DOOR_CYCLES);
                end
                ST_HOLD: begin
                    if (cnt_q == CW'(1)) begin
                        state_q    <= ST_IDLE;
                        lane_grant <= '0;
                        cnt_q      <= '0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef PARK_ARB_STATS_EN
    logic denied_new;

    assign denied_new = (state_q == ST_IDLE)
                      && |(blk_next & ~lane_blocked);

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_entries <= '0;
            stat_exits   <= '0;
            stat_denied  <= '0;
        end else begin
            if (entry_sensor && stat_entries != 8'hFF) begin
                stat_entries <= stat_entries + 8'd1;
            end
            if (exit_sensor && stat_exits != 8'hFF) begin
                stat_exits <= stat_exits + 8'd1;
            end
            if (denied_new && stat_denied != 8'hFF) begin
                stat_denied <= stat_denied + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_parking_lane_arbiter.sv
// Directed bench for parking_lane_arbiter (3 lanes, 4-cycle door hold).
// Stats checks compile in when PARK_ARB_STATS_EN is defined.
module tb_parking_lane_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] lane_req;
    logic       exit_req;
    logic [1:0] exit_loc;
    logic       full_light;
    logic       entry_sensor;
    logic       exit_sensor;
    logic [1:0] exit_location;
    logic       exit_ack;
    logic [2:0] lane_grant;
    logic [2:0] lane_blocked;
`ifdef PARK_ARB_STATS_EN
    logic [7:0] stat_entries;
    logic [7:0] stat_exits;
    logic [7:0] stat_denied;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    parking_lane_arbiter #(
        .NUM_LANES   (3),
        .DOOR_CYCLES (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .lane_req      (lane_req),
        .exit_req      (exit_req),
        .exit_loc      (exit_loc),
        .full_light    (full_light),
        .entry_sensor  (entry_sensor),
        .exit_sensor   (exit_sensor),
        .exit_location (exit_location),
        .exit_ack      (exit_ack),
        .lane_grant    (lane_grant),
        .lane_blocked  (lane_blocked)
`ifdef PARK_ARB_STATS_EN
        ,
        .stat_entries  (stat_entries),
        .stat_exits    (stat_exits),
        .stat_denied   (stat_denied)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_entry(input logic [2:0] req);
        lane_req = req;
        tick(1);
        lane_req = 3'b000;
        tick(5);
    endtask

    task automatic do_exit(input logic [1:0] loc);
        exit_req = 1'b1;
        exit_loc = loc;
        tick(1);
        exit_req = 1'b0;
        tick(1);
    endtask

    task automatic do_deny();
        full_light = 1'b1;
        lane_req   = 3'b001;
        tick(1);
        full_light = 1'b0;
        lane_req   = 3'b000;
        tick(1);
    endtask

    initial begin
        reset      = 1'b1;
        lane_req   = '0;
        exit_req   = 1'b0;
        exit_loc   = '0;
        full_light = 1'b0;
        tick(2);
        chk("rst_entry", entry_sensor, 0);
        chk("rst_exit", exit_sensor, 0);
        chk("rst_grant", lane_grant, 0);
        chk("rst_blk", lane_blocked, 0);
        reset = 1'b0;
        tick(1);

        // 1) round robin from pointer 0, 5-cycle grant
        lane_req = 3'b101;
        tick(1);
        chk("t1_entry", entry_sensor, 1);
        chk("t1_grant0", lane_grant, 3'b001);
        lane_req = 3'b100;
        for (int i = 1; i < 5; i++) begin
            tick(1);
            chk("t1_hold", lane_grant, 3'b001);
            chk("t1_pulse1", entry_sensor, 0);
        end
        tick(1);
        chk("t1_release", lane_grant, 3'b000);
        tick(1);
        chk("t1_next", lane_grant, 3'b100);
        chk("t1_entry2", entry_sensor, 1);
        lane_req = 3'b000;
        tick(5);
        chk("t1_end", lane_grant, 0);

        // 2) exit wins over a simultaneous entry
        exit_req = 1'b1;
        exit_loc = 2'd2;
        lane_req = 3'b010;
        tick(1);
        chk("t2_exit", exit_sensor, 1);
        chk("t2_ack", exit_ack, 1);
        chk("t2_loc", exit_location, 2);
        chk("t2_nogrant", lane_grant, 0);
        exit_req = 1'b0;
        tick(1);
        chk("t2_exit_off", exit_sensor, 0);
        chk("t2_wait", lane_grant, 0);
        tick(1);
        chk("t2_grant", lane_grant, 3'b010);
        chk("t2_entry", entry_sensor, 1);
        lane_req = 3'b000;
        tick(5);
        chk("t2_end", lane_grant, 0);

        // 3) full lot blocks all lanes
        full_light = 1'b1;
        lane_req   = 3'b111;
        tick(1);
        chk("t3_noentry", entry_sensor, 0);
        chk("t3_blk", lane_blocked, 3'b111);
        tick(1);
        chk("t3_nogrant", lane_grant, 0);
        full_light = 1'b0;
        tick(1);
        chk("t3_unblk", lane_blocked, 3'b000);
        chk("t3_grant", lane_grant, 3'b100);
        lane_req = 3'b000;
        tick(5);
        chk("t3_end", lane_grant, 0);

        // 4) exit raised mid-hold waits for the door
        lane_req = 3'b001;
        tick(1);
        chk("t4_grant", lane_grant, 3'b001);
        lane_req = 3'b000;
        tick(1);
        exit_req = 1'b1;
        exit_loc = 2'd3;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("t4_noexit", exit_sensor, 0);
        end
        chk("t4_release", lane_grant, 0);
        tick(1);
        chk("t4_exit", exit_sensor, 1);
        chk("t4_loc", exit_location, 3);
        exit_req = 1'b0;
        tick(1);

        // 5) reset during hold clears outputs and pointer
        lane_req = 3'b010;
        tick(1);
        chk("t5_grant", lane_grant, 3'b010);
        lane_req = 3'b000;
        tick(2);
        reset = 1'b1;
        tick(1);
        chk("t5_rgrant", lane_grant, 0);
        chk("t5_rentry", entry_sensor, 0);
        chk("t5_rexit", {exit_sensor, exit_ack, exit_location}, 0);
        reset = 1'b0;
        lane_req = 3'b110;
        tick(1);
        chk("t5_ptr0", lane_grant, 3'b010);
        lane_req = 3'b000;
        tick(5);
        chk("t5_end", lane_grant, 0);

`ifdef PARK_ARB_STATS_EN
        // 6) counters since the reset above: one entry so far
        do_entry(3'b001);
        do_entry(3'b100);
        do_exit(2'd1);
        do_deny();
        do_deny();
        chk("t6_entries", stat_entries, 3);
        chk("t6_exits", stat_exits, 1);
        chk("t6_denied", stat_denied, 2);
        for (int i = 0; i < 300; i++) begin
            do_entry(3'b010);
        end
        chk("t6_sat", stat_entries, 255);
        chk("t6_exits2", stat_exits, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
